// File: rtl/axi_stream_remove_header.sv
// AXI Stream header stripper: removes S = byte_strip_cnt+1 leading bytes per packet
// and re-aligns the remaining payload to the top of each output beat (registered output).
module axi_stream_remove_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    ready_strip,
   output logic                    drop_pkt
);

   typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

   localparam int unsigned W_U = DATA_BYTE_WD;
   localparam logic [BYTE_CNT_WD:0] W_L = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

   state_t                  state_q, state_d;
   logic [BYTE_CNT_WD:0]    s_q, s_d;
   logic [BYTE_CNT_WD:0]    hold_len_q, hold_len_d;
   logic [DATA_WD-1:0]      hold_q, hold_d;
   logic                    valid_out_q, valid_out_d;
   logic [DATA_WD-1:0]      data_out_q, data_out_d;
   logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
   logic                    last_out_q, last_out_d;
   logic                    drop_q, drop_d;

   logic                    out_free;
   logic                    acc;
   logic [BYTE_CNT_WD:0]    l_in;
   logic [BYTE_CNT_WD+3:0]  hold_sh;
   logic [BYTE_CNT_WD+3:0]  in_sh;
   logic [DATA_WD-1:0]      stream_beat;
   logic [DATA_WD-1:0]      flush_beat;
   logic [DATA_BYTE_WD-1:0] mask;

   function automatic logic [BYTE_CNT_WD:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
      logic [BYTE_CNT_WD:0] c;
      c = '0;
      for (int unsigned i = 0; i < W_U; i++) c = c + (BYTE_CNT_WD + 1)'(k[i]);
      return c;
   endfunction

   // top n byte lanes enabled (lane W-1 is first in stream order)
   function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [BYTE_CNT_WD+1:0] n);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < W_U; i++) m[i] = ((i + 32'(n)) >= W_U);
      return m;
   endfunction

   function automatic logic [DATA_WD-1:0] lanes(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < W_U; i++) b[8*i +: 8] = {8{k[i]}};
      return b;
   endfunction

   always_comb begin
      out_free    = !valid_out_q || ready_out;
      ready_strip = (state_q == IDLE);
      case (state_q)
         FIRST:   ready_in = 1'b1;
         STREAM:  ready_in = out_free;
         default: ready_in = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      hold_d      = hold_q;
      hold_len_d  = hold_len_q;
      valid_out_d = valid_out_q;
      data_out_d  = data_out_q;
      keep_out_d  = keep_out_q;
      last_out_d  = last_out_q;
      drop_d      = 1'b0;
      mask        = '0;

      acc         = valid_in && ready_in;
      l_in        = popcount(keep_in);
      hold_sh     = {s_q, 3'b000};
      in_sh       = {W_L - s_q, 3'b000};
      // S=W falls out naturally: hold shifts out entirely and the input passes unshifted
      stream_beat = (hold_q << hold_sh) | (data_in >> in_sh);
      flush_beat  = hold_q << hold_sh;

      if (ready_out) valid_out_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_strip) begin
               s_d     = {1'b0, byte_strip_cnt} + 1'b1;
               state_d = FIRST;
            end
         end
         FIRST: begin
            if (acc) begin
               hold_d     = data_in;
               hold_len_d = l_in;
               if (!last_in)       state_d = STREAM;
               else if (l_in > s_q) state_d = FLUSH;
               else begin
                  drop_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         STREAM: begin
            if (acc) begin
               hold_d      = data_in;
               hold_len_d  = l_in;
               valid_out_d = 1'b1;
               data_out_d  = stream_beat;
               keep_out_d  = '1;
               last_out_d  = 1'b0;
               if (last_in) begin
                  if (l_in > s_q) state_d = FLUSH;
                  else begin
                     mask       = top_mask({1'b0, W_L} - {1'b0, s_q} + {1'b0, l_in});
                     keep_out_d = mask;
                     data_out_d = stream_beat & lanes(mask);
                     last_out_d = 1'b1;
                     state_d    = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               mask        = top_mask({1'b0, hold_len_q - s_q});
               valid_out_d = 1'b1;
               keep_out_d  = mask;
               data_out_d  = flush_beat & lanes(mask);
               last_out_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= '0;
         hold_q      <= '0;
         hold_len_q  <= '0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
         keep_out_q  <= '0;
         last_out_q  <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         hold_q      <= hold_d;
         hold_len_q  <= hold_len_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         keep_out_q  <= keep_out_d;
         last_out_q  <= last_out_d;
         drop_q      <= drop_d;
      end
   end

   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;
   assign keep_out  = keep_out_q;
   assign last_out  = last_out_q;
   assign drop_pkt  = drop_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Bench for axi_stream_remove_header: directed packets plus randomized packets
// checked against a byte-queue reference model.
module tb_axi_stream_remove_header;

   localparam int DW = 32;
   localparam int W  = 4;
   localparam int CW = 2;

   logic          clk;
   logic          rst_n;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic [W-1:0]  keep_in;
   logic          last_in;
   logic          ready_in;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic [W-1:0]  keep_out;
   logic          last_out;
   logic          ready_out = 1'b1;
   logic          valid_strip;
   logic [CW-1:0] byte_strip_cnt;
   logic          ready_strip;
   logic          drop_pkt;

   axi_stream_remove_header #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_in(ready_in),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_out(ready_out),
      .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
      .drop_pkt(drop_pkt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      logic          l;
   } beat_t;

   int n_checks = 0;
   int n_errors = 0;
   int drop_seen = 0;
   int exp_drops = 0;
   bit mon_en = 1'b0;
   int ro_mode = 0;
   beat_t exp_q[$];
   logic [DW-1:0] pd[$];
   logic [W-1:0]  pk[$];
   byte unsigned  pb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
      beat_t b;
      b.d = d; b.k = k; b.l = l;
      exp_q.push_back(b);
   endtask

   always @(posedge clk) begin
      #1;
      case (ro_mode)
         0:       ready_out = 1'b1;
         1:       ready_out = ~ready_out;
         2:       ready_out = 1'($urandom_range(0, 1));
         default: ready_out = 1'b0;
      endcase
   end

   // Output monitor: scoreboard pop, stall stability and drop pulse counting
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic [W-1:0]  prev_k;
   logic          prev_l;
   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_data", 64'(data_out), 64'(prev_d));
            check("stall_keep", 64'(keep_out), 64'(prev_k));
            check("stall_last", 64'(last_out), 64'(prev_l));
         end
         prev_stall = valid_out && !ready_out;
         prev_d = data_out; prev_k = keep_out; prev_l = last_out;
         if (drop_pkt) drop_seen++;
         if (valid_out && ready_out) begin
            if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
            else begin
               beat_t e;
               e = exp_q.pop_front();
               check("out_data", 64'(data_out), 64'(e.d));
               check("out_keep", 64'(keep_out), 64'(e.k));
               check("out_last", 64'(last_out), 64'(e.l));
            end
         end
      end
   end

   // All driver tasks start and end one time unit after a rising edge.
   task automatic do_desc(input int cnt);
      bit hs;
      hs = 1'b0;
      valid_strip = 1'b1;
      byte_strip_cnt = CW'(cnt);
      for (int i = 0; i < 100 && !hs; i++) begin
         @(negedge clk);
         hs = ready_strip;
         @(posedge clk); #1;
      end
      if (!hs) check("desc_timeout", 64'd0, 64'd1);
      valid_strip = 1'b0;
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l,
                             input bit gaps);
      bit hs;
      hs = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
         valid_in = 1'b0;
         @(posedge clk); #1;
      end
      valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
      for (int i = 0; i < 100 && !hs; i++) begin
         @(negedge clk);
         hs = ready_in;
         @(posedge clk); #1;
      end
      if (!hs) check("beat_timeout", 64'd0, 64'd1);
      valid_in = 1'b0;
      data_in = $urandom;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && ready_strip;
      end
      if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      check("drop_count", 64'(drop_seen), 64'(exp_drops));
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input int cnt, input bit gaps);
      do_desc(cnt);
      for (int i = 0; i < pd.size(); i++) drive_beat(pd[i], pk[i], i == pd.size() - 1, gaps);
      drain();
   endtask

   // Packet beats from the byte queue; disabled lanes carry random garbage
   task automatic build_from_bytes();
      int n, nb;
      logic [DW-1:0] d;
      logic [W-1:0] k;
      n = pb.size();
      nb = (n + W - 1) / W;
      pd.delete(); pk.delete();
      for (int bi = 0; bi < nb; bi++) begin
         d = $urandom; k = '0;
         for (int j = 0; j < W; j++) begin
            if (bi * W + j < n) begin
               d[8*(W-1-j) +: 8] = pb[bi * W + j];
               k[W-1-j] = 1'b1;
            end
         end
         pd.push_back(d); pk.push_back(k);
      end
   endtask

   // Reference: drop the first S bytes, repack the rest W bytes per beat from the top
   task automatic model(input int cnt);
      int s, rem;
      logic [DW-1:0] d;
      logic [W-1:0] k;
      s = cnt + 1;
      if (pb.size() <= s) exp_drops++;
      else begin
         rem = pb.size() - s;
         for (int off = 0; off < rem; off += W) begin
            d = '0; k = '0;
            for (int j = 0; j < W; j++) begin
               if (off + j < rem) begin
                  d[8*(W-1-j) +: 8] = pb[s + off + j];
                  k[W-1-j] = 1'b1;
               end
            end
            push_exp(d, k, off + W >= rem);
         end
      end
   endtask

   task automatic pkt_two_beats();
      pd.delete(); pk.delete();
      pd.push_back(32'hAABBCCDD); pk.push_back(4'b1111);
      pd.push_back(32'h11223344); pk.push_back(4'b1100);
   endtask

   task automatic rand_pkt(input int cnt, input int n, input bit gaps);
      pb.delete();
      for (int i = 0; i < n; i++) pb.push_back(8'($urandom));
      build_from_bytes();
      model(cnt);
      send_pkt(cnt, gaps);
   endtask

   initial begin
      rst_n = 1'b0;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_strip = 1'b0; byte_strip_cnt = '0;
      #12;
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_keep_out", 64'(keep_out), 64'd0);
      check("rst_last_out", 64'(last_out), 64'd0);
      check("rst_drop", 64'(drop_pkt), 64'd0);
      check("rst_ready_in", 64'(ready_in), 64'd0);
      check("rst_ready_strip", 64'(ready_strip), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // S=1: two beats with one flush beat
      pkt_two_beats();
      push_exp(32'hBBCCDD11, 4'b1111, 1'b0);
      push_exp(32'h22000000, 4'b1000, 1'b1);
      send_pkt(0, 1'b0);

      // S=2: collapses into one last beat
      pkt_two_beats();
      push_exp(32'hCCDD1122, 4'b1111, 1'b1);
      send_pkt(1, 1'b0);
      check("ready_strip_after", 64'(ready_strip), 64'd1);

      // S=4: whole first beat removed
      pd.delete(); pk.delete();
      pd.push_back(32'h01020304); pk.push_back(4'b1111);
      pd.push_back(32'h05060708); pk.push_back(4'b1111);
      pd.push_back(32'h090A0B0C); pk.push_back(4'b1110);
      push_exp(32'h05060708, 4'b1111, 1'b0);
      push_exp(32'h090A0B00, 4'b1110, 1'b1);
      send_pkt(3, 1'b0);

      // Whole packet is header
      pd.delete(); pk.delete();
      pd.push_back(32'hAA000000); pk.push_back(4'b1000);
      exp_drops++;
      send_pkt(0, 1'b0);

      // S=1, 4 beats, toggling backpressure and input gaps
      ro_mode = 1;
      rand_pkt(0, 16, 1'b1);
      rand_pkt(0, 13, 1'b1);

      for (int p = 0; p < 40; p++) begin
         ro_mode = $urandom_range(0, 2);
         rand_pkt($urandom_range(0, 3), $urandom_range(1, 14), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in STREAM while an output beat is stalled
      ro_mode = 3;
      mon_en = 1'b0;
      @(posedge clk); #1;
      do_desc(0);
      drive_beat(32'h10203040, 4'b1111, 1'b0, 1'b0);
      drive_beat(32'h50607080, 4'b1111, 1'b0, 1'b0);
      @(negedge clk);
      check("pre_rst_valid", 64'(valid_out), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(valid_out), 64'd0);
      check("async_rst_data", 64'(data_out), 64'd0);
      check("async_rst_keep", 64'(keep_out), 64'd0);
      valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = '1; last_in = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_ready_in", 64'(ready_in), 64'd0);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      ro_mode = 0;
      exp_q.delete();
      drop_seen = 0; exp_drops = 0;
      mon_en = 1'b1;

      pkt_two_beats();
      push_exp(32'hBBCCDD11, 4'b1111, 1'b0);
      push_exp(32'h22000000, 4'b1000, 1'b1);
      send_pkt(0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
